ape_fetch_pipe: RTL



---
 rtl/ape_pkg.sv | 15 +
 rtl/ape_fetch_slice.sv | 66 ++++++
 rtl/ape_fetch_pipe.sv | 84 ++++++++
 3 files changed

// File: rtl/ape_pkg.sv
// Shared types and limits for the APE fetch path: default beat layout and maximum slice count.
package ape_pkg;

  localparam int unsigned APE_KEY_W           = 64;
  localparam int unsigned APE_DATA_W          = 34;
  localparam int unsigned APE_TAG_W           = 16;
  localparam int unsigned APE_FETCH_MAX_DEPTH = 8;

  typedef struct packed {
    logic [APE_KEY_W-1:0]  key;
    logic [APE_DATA_W-1:0] data;
    logic [APE_TAG_W-1:0]  tag;
  } ape_fetch_beat_t;

endpackage

// File: rtl/ape_fetch_slice.sv
// One skid-buffered register slice: main + skid registers, registered ready (no out_ready->in_ready path).
// Optional synchronous flush when APE_FETCH_FLUSH_EN is defined.
module ape_fetch_slice
  import ape_pkg::*;
#(
  parameter int unsigned W = $bits(ape_fetch_beat_t)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
`ifdef APE_FETCH_FLUSH_EN
  input  logic         flush_i,
`endif
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_beat_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_beat_o
);

  logic         main_v_q;
  logic         skid_v_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_fire;
  logic         main_free;

  assign in_ready_o  = ~skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_beat_o  = main_q;

  // An accept is impossible while skid is full, so a freeing main takes skid or the new beat, never both.
  assign in_fire   = in_valid_i & ~skid_v_q;
  assign main_free = ~main_v_q | out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
`ifdef APE_FETCH_FLUSH_EN
    end else if (flush_i) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
`endif
    end else if (main_free) begin
      main_v_q <= skid_v_q | in_fire;
      skid_v_q <= 1'b0;
    end else if (in_fire) begin
      skid_v_q <= 1'b1;
    end
  end

  // Payload carries no reset; written only when its valid bit is being set.
  always_ff @(posedge clk_i) begin
    if (main_free) begin
      if (skid_v_q) begin
        main_q <= skid_q;
      end else if (in_fire) begin
        main_q <= in_beat_i;
      end
    end else if (in_fire) begin
      skid_q <= in_beat_i;
    end
  end

endmodule

// File: rtl/ape_fetch_pipe.sv
// Elastic fetch stage: DEPTH chained skid slices carrying {key, data, tag} with registered occupancy.
// Optional flush port and logic when APE_FETCH_FLUSH_EN is defined.
module ape_fetch_pipe
  import ape_pkg::*;
#(
  parameter int unsigned KEY_W  = APE_KEY_W,
  parameter int unsigned DATA_W = APE_DATA_W,
  parameter int unsigned TAG_W  = APE_TAG_W,
  parameter int unsigned DEPTH  = 1
) (
  input  logic                           clk_1,
  input  logic                           rst_n,
`ifdef APE_FETCH_FLUSH_EN
  input  logic                           flush,
`endif
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [KEY_W-1:0]               key_in,
  input  logic [DATA_W-1:0]              data_i,
  input  logic [TAG_W-1:0]               tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [KEY_W-1:0]               key_o,
  output logic [DATA_W-1:0]              data_o,
  output logic [TAG_W-1:0]               tag_o,
  output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned W     = KEY_W + DATA_W + TAG_W;
  localparam int unsigned OCC_W = $clog2(2*DEPTH+1);

  logic [DEPTH:0] vld;
  logic [DEPTH:0] rdy;
  logic [W-1:0]   beat [DEPTH+1];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic in_fire;
  logic out_fire;

  assign vld[0]                  = in_valid;
  assign beat[0]                 = {key_in, data_i, tag};
  assign in_ready                = rdy[0];
  assign rdy[DEPTH]              = out_ready;
  assign out_valid               = vld[DEPTH];
  assign {key_o, data_o, tag_o}  = beat[DEPTH];
  assign occupancy               = occ_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slice
    ape_fetch_slice #(.W(W)) u_slice (
      .clk_i       (clk_1),
      .rst_ni      (rst_n),
`ifdef APE_FETCH_FLUSH_EN
      .flush_i     (flush),
`endif
      .in_valid_i  (vld[i]),
      .in_ready_o  (rdy[i]),
      .in_beat_i   (beat[i]),
      .out_valid_o (vld[i+1]),
      .out_ready_i (rdy[i+1]),
      .out_beat_o  (beat[i+1])
    );
  end

  // Tracking boundary transfers equals the sum of all slice valid bits after each edge.
  assign in_fire  = in_valid & rdy[0];
  assign out_fire = vld[DEPTH] & out_ready;

  always_comb begin
    occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
`ifdef APE_FETCH_FLUSH_EN
    end else if (flush) begin
      occ_q <= '0;
`endif
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule
